// File: rtl/ex_muldiv_seq_if.sv
// rtl/ex_muldiv_seq_if.sv - EX-stage multiply/divide request and result bundle
interface ex_muldiv_seq_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             flush;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, opA, opB, flush,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, op, opA, opB, flush,
        output busy, stall, done, result
    );
endinterface

// File: rtl/ex_muldiv_seq.sv
// rtl/ex_muldiv_seq.sv - iterative shift-add multiplier / restoring divider for the EX stage
module ex_muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    ex_muldiv_seq_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_opb;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_result;

    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod_nxt;
    logic [WIDTH:0]     w_trial;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quot_nxt;
    logic               w_last;
    logic [WIDTH-1:0]   w_sel;

    // Multiply: add multiplier into the high half with carry, then shift the carry back in.
    assign w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opb} : '0);
    assign w_prod_nxt = {w_sum, r_prod[WIDTH-1:1]};

    // Divide: remainder is always below the divisor, so bit WIDTH of the trial is the borrow.
    assign w_trial    = {r_rem, r_quot[WIDTH-1]} - {1'b0, r_opb};
    assign w_qbit     = ~w_trial[WIDTH];
    assign w_rem_nxt  = w_qbit ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quot[WIDTH-1]};
    assign w_quot_nxt = {r_quot[WIDTH-2:0], w_qbit};

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_sel = '0;
        case (r_op)
            2'b00:   w_sel = w_prod_nxt[WIDTH-1:0];
            2'b01:   w_sel = w_prod_nxt[2*WIDTH-1:WIDTH];
            2'b10:   w_sel = w_quot_nxt;
            default: w_sel = w_rem_nxt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_opb    <= '0;
            r_prod   <= '0;
            r_rem    <= '0;
            r_quot   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.flush) begin
                        r_op  <= bus.op;
                        r_opb <= bus.opB;
                        r_cnt <= '0;
                        if (bus.op[1]) begin
                            r_rem  <= '0;
                            r_quot <= bus.opA;
                        end else begin
                            r_prod <= {{WIDTH{1'b0}}, bus.opA};
                        end
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_op[1]) begin
                            r_rem  <= w_rem_nxt;
                            r_quot <= w_quot_nxt;
                        end else begin
                            r_prod <= w_prod_nxt;
                        end
                        // Result is captured with the final step so it is already valid during DONE.
                        if (w_last) begin
                            r_result <= w_sel;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy   = (r_state == S_CALC) || (r_state == S_DONE);
    assign bus.stall  = ((r_state == S_IDLE) && bus.start && !bus.flush) || (r_state == S_CALC);
    assign bus.done   = (r_state == S_DONE);
    assign bus.result = r_result;
endmodule
